// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32 load/store
// opcodes, Funct3 access codes, FSM states and the default bus timeout.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: selects the addressed byte/halfword of a
// bus word and sign- or zero-extends it according to Funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: o_data gets a default before the case so no path leaves it unassigned (no latch).
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'b0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'b0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory access per memory instruction over a
// req/gnt/rvalid bus, stalls the core meanwhile, flags misalignment/timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] Mem_addr,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] load_data,
  output logic             op_done,
  output logic             stall,
  output logic             misaligned,
  output logic             bus_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [3:0]       bus_be,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_f3;
  logic [1:0]       r_lane;
  logic             w_is_load, w_is_store, w_mem_op, w_misal, w_timeout;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata, w_load_ext;

  assign w_is_load  = op_valid && (opcode == OP_LOAD) &&
                      (Funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  assign w_is_store = op_valid && (opcode == OP_STORE) &&
                      (Funct3 inside {F3_SB, F3_SH, F3_SW});
  assign w_mem_op   = w_is_load || w_is_store;
  // Funct3[1:0] encodes access size for both loads and stores.
  assign w_misal    = ((Funct3[1:0] == 2'b01) && Mem_addr[0]) ||
                      ((Funct3[1:0] == 2'b10) && (Mem_addr[1:0] != 2'b00));
  assign w_timeout  = (r_cnt == CNT_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    if (w_is_store) begin
      case (Funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << Mem_addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_be    = Mem_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata  (bus_rdata),
    .i_funct3 (r_f3),
    .i_lane   (r_lane),
    .o_data   (w_load_ext)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mem_op) w_next = w_misal ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (bus_gnt)        w_next = bus_we ? ST_DONE : ST_WAIT;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_WAIT: if (bus_rvalid || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign stall   = ((r_state == ST_IDLE) && w_mem_op) ||
                   (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign op_done = (r_state == ST_DONE);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_f3       <= '0;
      r_lane     <= '0;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (w_mem_op) begin
          r_f3   <= Funct3;
          r_lane <= Mem_addr[1:0];
          r_cnt  <= '0;
          if (w_misal) begin
            misaligned <= 1'b1;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= w_is_store;
            bus_addr  <= {Mem_addr[WIDTH-1:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus_gnt) begin
            bus_req <= 1'b0;
          end else if (w_timeout) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus_rvalid)     load_data <= w_load_ext;
          else if (w_timeout) bus_err   <= 1'b1;
        end
        ST_DONE: begin
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the ALU's load/store path: accepts the effective address computed by the ALU (`Mem_addr`), RS2 store data and `Funct3`.
- Runs one access on a word-wide data-memory bus with a req/gnt/rvalid handshake.
- Returns the aligned, extended load result to writeback.
- Stalls the single-cycle core while an access is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- WIDTH, 32, datapath and address width; only 32 is supported.
- TIMEOUT, 16, max cycles spent in REQ plus WAIT before `bus_err`; counter width is `$clog2(TIMEOUT+1)`.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge)
- op_valid  in  1  current instruction presented this cycle
- opcode  in  7  instruction opcode
- Funct3  in  3  access size/sign
- Mem_addr  in  WIDTH  byte effective address from ALU
- store_data  in  WIDTH  RS2 value
- load_data  out  WIDTH  extended load result, registered
- op_done  out  1  one-cycle completion pulse
- stall  out  1  hold the core's PC/regfile write
- misaligned  out  1  qualifies `op_done`: alignment fault, no bus access made
- bus_err  out  1  qualifies `op_done`: timeout
- bus_req  out  1  access request
- bus_we  out  1  1 = write
- bus_addr  out  WIDTH  word address, `{Mem_addr[31:2],2'b00}`
- bus_be  out  4  byte enables
- bus_wdata  out  WIDTH  lane-replicated write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  WIDTH  read data

Behaviour:
- Reset (`rst`=0 at edge): state=IDLE. All outputs 0: `load_data`, `op_done`, `misaligned`, `bus_err`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`. Timeout counter 0.
- Reset mid-operation: `bus_req` drops at that edge. An `rvalid` arriving later in IDLE is ignored.
- Memory op definition: `op_valid` && `opcode` ∈ {0000011 load, 0100011 store} && legal `Funct3`.
  - Legal load `Funct3`: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Legal store `Funct3`: 0 SB, 1 SH, 2 SW.
  - Any other `opcode`/`Funct3` combination is ignored: no bus activity, no `op_done`, `stall`=0.
- Alignment check: halfword needs `addr[0]`=0; word needs `addr[1:0]`=0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, memory op, aligned: latch `bus_*` fields, assert `bus_req`, go to REQ.
  - IDLE, memory op, misaligned: go to DONE with `misaligned`=1; `bus_req` stays 0.
  - REQ: hold `bus_req` and all `bus_*` fields stable until `bus_gnt`=1 is sampled.
    - Store granted: go to DONE.
    - Load granted: go to WAIT.
    - `bus_req` deasserts at the gnt edge.
  - WAIT: on `bus_rvalid`, register the extracted `load_data` and go to DONE.
  - DONE: `op_done`=1 for exactly one cycle, then IDLE. `misaligned`/`bus_err` are valid only with `op_done` and clear in IDLE.
- Timeout: counter clears on IDLE→REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT:
  - drop `bus_req`;
  - set `bus_err`=1 and go to DONE;
  - leave `load_data` unchanged.
  - If `gnt`/`rvalid` arrives in the same cycle as timeout, the handshake wins.
- `rvalid` in the same cycle as `gnt` is ignored; `rvalid` is accepted from the cycle after `gnt`.
- Stall rule: `stall` = (IDLE && memory op) || REQ || WAIT. `stall` is 0 in DONE, so the core advances on the `op_done` cycle.
- `op_valid` is ignored outside IDLE.
- Latency: op accepted at edge N → `bus_req` from N+1.
  - Store with `gnt` at N+1 → `op_done` at N+2.
  - Load with `gnt` at N+1 and `rvalid` at N+2 → `load_data`/`op_done` at N+3.
  - Misaligned → `op_done` at N+1.
- Store lanes, with lane = `addr[1:0]`:
  - SB: `be`=1<<lane, `wdata`={4{rs2[7:0]}}.
  - SH: `be`=0011 (lane 0) or 1100 (lane 2), `wdata`={2{rs2[15:0]}}.
  - SW: `be`=1111, `wdata`=rs2.
  - Loads drive `be`=1111, `we`=0.
- Load extract:
  - LB/LBU: `rdata[8*lane+:8]`, sign- or zero-extended.
  - LH/LHU: `rdata[16*addr[1]+:16]`, sign- or zero-extended.
  - LW: full word.
- Latched `Funct3`/lane are used for extraction; inputs may change after acceptance.

Decomposition:
- Shared package `lsu_pkg` holds:
  - OP_LOAD / OP_STORE opcode constants;
  - F3_LB/LH/LW/LBU/LHU/SB/SH/SW codes;
  - state enum {IDLE, REQ, WAIT, DONE};
  - TIMEOUT default.
- Sub-module `load_align`: combinational (`rdata`, `funct3`, lane) → extended `load_data`. It is unit-testable on its own.
- FSM, store lane generation and timeout counter stay in `load_store_unit`.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, `gnt` 1 cycle after `req` → bus_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; `op_done` at N+2; `stall` high N..N+1.
- LB addr 0x203, rdata 0x80FF_0000 → `load_data` 0xFFFFFF80; repeat as LBU → 0x00000080.
- LH addr 0x202, rdata 0x8001_1234 → 0xFFFF8001; SH addr 0x202, rs2 0x0000ABCD → be 1100, wdata 0xABCDABCD.
- LW addr 0x101 → no `bus_req`, `op_done`+`misaligned` at N+1; next aligned op proceeds normally.
- `gnt` held low 16 cycles → `bus_req` drops, `op_done`+`bus_err`, `load_data` unchanged; late `gnt` ignored.
- `rst`=0 while in WAIT → all outputs 0 next edge; subsequent `rvalid` produces no `op_done`.
